// File: rtl/div_sched.sv
// div_sched: reservation station feeding the iterative divide unit.
// Compacting queue (entry 0 = oldest), CDB operand snooping, oldest-ready issue.

package div_sched_pkg;
  localparam int CDB_TAG_W = 4;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] dest_ROB_entry;
    logic [31:0]          result;
  } CDB_packet_t;
endpackage

// One operand slot: captures the CDB result when its pending tag is broadcast.
module div_sched_src #(
  parameter int TAG_W = 4
) (
  input  logic             en,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_res,
  input  logic [31:0]      val_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             rdy_i,
  output logic [31:0]      val_o,
  output logic             rdy_o
);
  logic hit;

  assign hit   = en & cdb_valid & ~rdy_i & (tag_i == cdb_tag);
  assign val_o = hit ? cdb_res : val_i;
  assign rdy_o = rdy_i | hit;
endmodule

module div_sched
  import div_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = CDB_TAG_W,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [TAG_W-1:0] disp_rob,
  input  logic             disp_aluop,
  input  logic [31:0]      disp_src1_val,
  input  logic [31:0]      disp_src2_val,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic             cdb_valid,
  input  CDB_packet_t      cdb_in,
  input  logic             div_ready,
  output logic             div_valid,
  output logic [TAG_W-1:0] div_rob,
  output logic             div_aluop,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  output logic [CW-1:0]    count
);
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob;
    logic             aluop;
    logic [31:0]      s1_val;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [31:0]      s2_val;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_rdy;
  } ent_t;

  ent_t [DEPTH-1:0]        ent_q, ent_d, ent_w;
  ent_t                    disp_e;
  logic [CW-1:0]           count_q, count_d;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DEPTH-1:0][31:0]  w1_val, w2_val;
  logic [DEPTH-1:0]        w1_rdy, w2_rdy, elig;
  logic [31:0]             d1_val, d2_val;
  logic                    d1_rdy, d2_rdy;
  logic [SW-1:0]           sel;
  logic                    any_elig, issue, disp_fire;
  logic [CW-1:0]           widx;

  assign cdb_tag = TAG_W'(cdb_in.dest_ROB_entry);

  // Per-entry wakeup: both sources snoop the same broadcast independently.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    div_sched_src #(.TAG_W(TAG_W)) u_s1 (
      .en(ent_q[g].valid), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_res(cdb_in.result),
      .val_i(ent_q[g].s1_val), .tag_i(ent_q[g].s1_tag), .rdy_i(ent_q[g].s1_rdy),
      .val_o(w1_val[g]), .rdy_o(w1_rdy[g]));
    div_sched_src #(.TAG_W(TAG_W)) u_s2 (
      .en(ent_q[g].valid), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_res(cdb_in.result),
      .val_i(ent_q[g].s2_val), .tag_i(ent_q[g].s2_tag), .rdy_i(ent_q[g].s2_rdy),
      .val_o(w2_val[g]), .rdy_o(w2_rdy[g]));
  end

  // Dispatch-time bypass so a result broadcast this cycle is not missed.
  div_sched_src #(.TAG_W(TAG_W)) u_d1 (
    .en(1'b1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_res(cdb_in.result),
    .val_i(disp_src1_val), .tag_i(disp_src1_tag), .rdy_i(disp_src1_rdy),
    .val_o(d1_val), .rdy_o(d1_rdy));
  div_sched_src #(.TAG_W(TAG_W)) u_d2 (
    .en(1'b1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_res(cdb_in.result),
    .val_i(disp_src2_val), .tag_i(disp_src2_tag), .rdy_i(disp_src2_rdy),
    .val_o(d2_val), .rdy_o(d2_rdy));

  // Woken view of every entry plus the incoming dispatch entry.
  always_comb begin
    ent_w = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i].s1_val = w1_val[i];
      ent_w[i].s1_rdy = w1_rdy[i];
      ent_w[i].s2_val = w2_val[i];
      ent_w[i].s2_rdy = w2_rdy[i];
      elig[i]         = ent_q[i].valid & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
    end
    disp_e        = '0;
    disp_e.valid  = 1'b1;
    disp_e.rob    = disp_rob;
    disp_e.aluop  = disp_aluop;
    disp_e.s1_val = d1_val;
    disp_e.s1_tag = disp_src1_tag;
    disp_e.s1_rdy = d1_rdy;
    disp_e.s2_val = d2_val;
    disp_e.s2_tag = disp_src2_tag;
    disp_e.s2_rdy = d2_rdy;
  end

  // Oldest eligible entry wins (scan from the top so the lowest index sticks).
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = SW'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign disp_ready = (count_q < CW'(DEPTH));
  assign issue      = div_ready & any_elig & ~flush;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign widx       = count_q - CW'(issue);

  // Next state: remove/compact on issue, append on dispatch, flush clears all.
  always_comb begin
    ent_d   = ent_w;
    count_d = count_q + CW'(disp_fire) - CW'(issue);
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (SW'(i) >= sel) ent_d[i] = ent_w[i+1];
      ent_d[DEPTH-1] = '0;
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == widx) ent_d[i] = disp_e;
    end
    if (flush) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign div_valid    = issue;
  assign div_rob      = ent_q[sel].rob;
  assign div_aluop    = ent_q[sel].aluop;
  assign div_dividend = ent_q[sel].s1_val;
  assign div_divisor  = ent_q[sel].s2_val;
  assign count        = count_q;
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus random traffic vs a queue model.
module tb_div_sched;
  import div_sched_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready, disp_aluop;
  logic [3:0]  disp_rob, disp_src1_tag, disp_src2_tag;
  logic [31:0] disp_src1_val, disp_src2_val;
  logic        disp_src1_rdy, disp_src2_rdy, cdb_valid, div_ready;
  CDB_packet_t cdb_in;
  logic        div_valid, div_aluop;
  logic [3:0]  div_rob;
  logic [31:0] div_dividend, div_divisor;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  rob;
    logic        aluop;
    logic [31:0] v1, v2;
    logic [3:0]  t1, t2;
    bit          r1, r2;
  } m_ent_t;
  m_ent_t q[$];

  div_sched #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
    .disp_aluop(disp_aluop), .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .cdb_valid(cdb_valid), .cdb_in(cdb_in), .div_ready(div_ready),
    .div_valid(div_valid), .div_rob(div_rob), .div_aluop(div_aluop),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .count(count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    disp_valid = 0; flush = 0; cdb_valid = 0;
    cdb_in = '0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic op,
                      input logic [31:0] v1, input logic [3:0] t1, input bit r1,
                      input logic [31:0] v2, input logic [3:0] t2, input bit r2);
    disp_valid = 1; disp_rob = rob; disp_aluop = op;
    disp_src1_val = v1; disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_val = v2; disp_src2_tag = t2; disp_src2_rdy = r2;
  endtask

  // Called at a negedge with inputs applied: check outputs, advance the model.
  task automatic step();
    int     sel;
    bit     fire_i, room;
    m_ent_t e;
    #1;
    sel = -1;
    foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
    room   = q.size() < DEPTH;
    fire_i = div_ready && (sel >= 0) && !flush;
    chk("div_valid", {31'b0, div_valid}, {31'b0, fire_i});
    chk("disp_ready", {31'b0, disp_ready}, {31'b0, room});
    chk("count", {29'b0, count}, q.size());
    if (fire_i) begin
      chk("div_rob", {28'b0, div_rob}, {28'b0, q[sel].rob});
      chk("div_aluop", {31'b0, div_aluop}, {31'b0, q[sel].aluop});
      chk("div_dividend", div_dividend, q[sel].v1);
      chk("div_divisor", div_divisor, q[sel].v2);
    end
    if (flush) q.delete();
    else begin
      if (cdb_valid)
        foreach (q[i]) begin
          if (!q[i].r1 && q[i].t1 == cdb_in.dest_ROB_entry) begin q[i].r1 = 1; q[i].v1 = cdb_in.result; end
          if (!q[i].r2 && q[i].t2 == cdb_in.dest_ROB_entry) begin q[i].r2 = 1; q[i].v2 = cdb_in.result; end
        end
      if (fire_i) q.delete(sel);
      if (disp_valid && room) begin
        e.rob = disp_rob; e.aluop = disp_aluop;
        e.v1 = disp_src1_val; e.t1 = disp_src1_tag; e.r1 = disp_src1_rdy;
        e.v2 = disp_src2_val; e.t2 = disp_src2_tag; e.r2 = disp_src2_rdy;
        if (cdb_valid && !e.r1 && e.t1 == cdb_in.dest_ROB_entry) begin e.r1 = 1; e.v1 = cdb_in.result; end
        if (cdb_valid && !e.r2 && e.t2 == cdb_in.dest_ROB_entry) begin e.r2 = 1; e.v2 = cdb_in.result; end
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 0; div_ready = 0; idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0); disp_valid = 0;
    #3;
    chk("rst_div_valid", {31'b0, div_valid}, 0);
    chk("rst_disp_ready", {31'b0, disp_ready}, 1);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_dividend", div_dividend, 0);
    @(negedge clk);
    reset = 1;

    // Single ready op issues the following cycle.
    div_ready = 1;
    disp(3, 1, 50, 0, 1, 5, 0, 1); step();
    idle(); #1;
    chk("t1_valid", {31'b0, div_valid}, 1);
    chk("t1_rob", {28'b0, div_rob}, 3);
    chk("t1_dividend", div_dividend, 50);
    chk("t1_divisor", div_divisor, 5);
    step();
    step();

    // Younger ready op bypasses an older waiting one; CDB wakes the older.
    disp(1, 0, 100, 0, 1, 0, 7, 0); step();
    disp(2, 1, 20, 0, 1, 4, 0, 1); step();
    idle(); cdb_valid = 1; cdb_in.dest_ROB_entry = 7; cdb_in.result = 9; #1;
    chk("t2_first_rob", {28'b0, div_rob}, 2);
    step();
    idle(); #1;
    chk("t2_second_rob", {28'b0, div_rob}, 1);
    chk("t2_divisor", div_divisor, 9);
    step();

    // Dispatch-time capture of a same-cycle broadcast.
    disp(5, 1, 0, 4, 0, 7, 0, 1); cdb_valid = 1;
    cdb_in.dest_ROB_entry = 4; cdb_in.result = -32'sd50; step();
    idle(); #1;
    chk("t3_valid", {31'b0, div_valid}, 1);
    chk("t3_dividend", div_dividend, 32'hFFFF_FFCE);
    step();

    // Fill to full, then drain oldest-first.
    div_ready = 0;
    for (int i = 0; i < 4; i++) begin disp(4'(8 + i), 0, i + 1, 0, 1, 3, 0, 1); step(); end
    idle(); #1;
    chk("t4_full_ready", {31'b0, disp_ready}, 0);
    chk("t4_full_count", {29'b0, count}, 4);
    div_ready = 1; #1;
    chk("t4_no_bypass", {31'b0, disp_ready}, 0);
    chk("t4_rob0", {28'b0, div_rob}, 8);
    step();
    #1;
    chk("t4_ready_after", {31'b0, disp_ready}, 1);
    chk("t4_rob1", {28'b0, div_rob}, 9);
    step(); step(); step();

    // Same-cycle dispatch + issue keeps count.
    div_ready = 0;
    disp(1, 0, 11, 0, 1, 1, 0, 1); step();
    disp(2, 0, 12, 0, 1, 1, 0, 1); step();
    div_ready = 1; disp(3, 1, 13, 0, 1, 1, 0, 1); step();
    idle(); #1;
    chk("t5_count", {29'b0, count}, 2);
    chk("t5_rob", {28'b0, div_rob}, 2);
    step();
    #1;
    chk("t5_rob_next", {28'b0, div_rob}, 3);
    step();

    // Flush blocks issue and empties the station.
    div_ready = 0;
    for (int i = 0; i < 3; i++) begin disp(4'(4 + i), 0, 7, 0, 1, 1, 0, 1); step(); end
    idle(); flush = 1; div_ready = 1; #1;
    chk("t6_flush_valid", {31'b0, div_valid}, 0);
    step();
    idle(); #1;
    chk("t6_flush_count", {29'b0, count}, 0);
    step();

    // Asynchronous reset mid-cycle.
    div_ready = 0;
    for (int i = 0; i < 3; i++) begin disp(4'(4 + i), 1, 99, 0, 1, 3, 0, 1); step(); end
    idle(); div_ready = 1; #2;
    reset = 0; #1;
    chk("t7_count", {29'b0, count}, 0);
    chk("t7_valid", {31'b0, div_valid}, 0);
    chk("t7_disp_ready", {31'b0, disp_ready}, 1);
    chk("t7_dividend", div_dividend, 0);
    q.delete();
    #1 reset = 1;
    @(negedge clk);

    // Random traffic against the queue model.
    for (int c = 0; c < 2000; c++) begin
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_rob      = 4'($urandom);
      disp_aluop    = 1'($urandom);
      disp_src1_val = $urandom; disp_src2_val = $urandom;
      disp_src1_tag = 4'($urandom_range(0, 7)); disp_src2_tag = 4'($urandom_range(0, 7));
      disp_src1_rdy = 1'($urandom); disp_src2_rdy = 1'($urandom);
      cdb_valid     = 1'($urandom);
      cdb_in.dest_ROB_entry = 4'($urandom_range(0, 7));
      cdb_in.result = $urandom;
      div_ready     = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Reservation-station scheduler for the iterative integer divide functional unit.
- Holds up to DEPTH dispatched div/remu ops and captures missing operands by snooping the CDB.
- Issues the oldest fully-ready op to the divider whenever the divider reports ready.
- Sits between rename/dispatch and the divide unit; the divider's own CDB output path is unchanged.

Parameters:
- DEPTH, 4, number of station entries (2..8); occupancy counter is $clog2(DEPTH+1) bits.
- TAG_W, 4, ROB entry / operand tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush (mispredict); clears all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept this cycle; = (count < DEPTH).
- disp_rob  in  TAG_W  destination ROB entry.
- disp_aluop  in  1  1 = div (signed quotient), 0 = remu.
- disp_src1_val / disp_src2_val  in  32  operand values (dividend / divisor).
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer ROB entry when the operand is not ready.
- disp_src1_rdy / disp_src2_rdy  in  1  operand value already valid.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_in  in  CDB_packet_t  broadcast; uses dest_ROB_entry and result.
- div_ready  in  1  divide unit idle.
- div_valid  out  1  issue strobe to divide valid_in.
- div_rob  out  TAG_W  issued ROB entry.
- div_aluop  out  1  issued op select.
- div_dividend / div_divisor  out  32  issued operands.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (reset=0, async): all entries invalid; count=0; div_valid=0; disp_ready=1. Data outputs are 0.
- Storage is a compacting queue. Entry 0 is the oldest; valid entries are contiguous from index 0.
- Each entry holds: valid, rob, aluop, src1/src2 value, tag, and rdy.
- Entry i is eligible when valid and both rdy bits are set, all registered. A CDB wakeup in cycle t makes the entry eligible in cycle t+1.
- Select: eligible entry with the lowest index. div_valid = div_ready & any eligible & ~flush. Issue outputs are combinational from the selected entry.
- Issue fires in the cycle div_valid=1. The selected entry is removed, and entries above it shift down one index at the clock edge.
- Dispatch fires when disp_valid & disp_ready. The new entry is written at index count, or count-1 if an issue fires the same cycle.
- Same-cycle issue + dispatch: count unchanged.
- Dispatch capture bypass: if cdb_valid and cdb dest_ROB_entry equals a non-ready disp tag, capture cdb result and set rdy at dispatch.
- Wakeup: every valid entry with a non-ready src whose tag matches a valid CDB broadcast captures the result and sets rdy. Both srcs may wake on the same broadcast.
- A wakeup on an entry that shifts this cycle lands in its new index.
- flush=1: all entries invalid, count=0 next edge; no issue that cycle (div_valid=0); dispatch that cycle is dropped.
- Full (count=DEPTH): disp_ready=0, even if an issue fires the same cycle (no full-bypass).
- Empty or none eligible: div_valid=0.
- div_ready deasserted: no removal; entries keep waking.
- Async reset asserted mid-operation clears state immediately, regardless of clock.
- Operands are passed as raw 32-bit values. Sign handling is the divider's responsibility.

Test Plan:
- Reset, then dispatch rob=3, aluop=1, 50/5, both rdy, div_ready=1 -> div_valid=1 the next cycle with div_rob=3, dividend=50, divisor=5; count returns to 0.
- Dispatch rob=1 src2 tag=7 not ready, then rob=2 both ready, div_ready=1 -> rob=2 issues first. CDB dest=7 result=9 -> rob=1 issues one cycle later with divisor=9.
- Dispatch rob=5 src1 tag=4, with cdb_valid dest=4 result=-50 in the same cycle -> entry captured ready; issues next cycle with dividend=0xFFFFFFCE.
- Fill 4 entries with div_ready=0 -> disp_ready=0, count=4. Raise div_ready -> issue order is the dispatch order (oldest-first); disp_ready=1 the cycle after the first issue.
- Same-cycle dispatch + issue at count=2 -> count stays 2; new entry lands at index 1.
- With 3 entries, assert flush while div_ready=1 -> div_valid=0 that cycle; count=0 next. Then assert reset low mid-cycle -> outputs clear without a clock edge.
